// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } seg_gp_t;

   function automatic int nseg(input int width, input int seg_w);
      return width / seg_w;
   endfunction

   function automatic bit seg_cfg_ok(input int width, input int seg_w);
      return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
   endfunction

endpackage

// File: rtl/pipelined_cla_adder_segment.sv
// cla_segment: combinational SEG_W-bit lookahead unit built from prefix group generate/propagate.
module cla_segment
   import cla_pkg::*;
#(
   parameter int SEG_W = 4
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin,
   output logic [SEG_W-1:0] sum,
   output logic             cout,
   output logic             msb_cin
);

   seg_gp_t          bit_gp_s [SEG_W];
   seg_gp_t          pre_gp_s [SEG_W];
   logic [SEG_W:0]   carry_s;

   // Every carry is a two-level function of the prefix group terms and cin.
   always_comb begin
      carry_s    = {(SEG_W+1){1'b0}};
      carry_s[0] = cin;
      sum        = {SEG_W{1'b0}};
      for (int i = 0; i < SEG_W; i++) begin
         bit_gp_s[i].g = a[i] & b[i];
         bit_gp_s[i].p = a[i] ^ b[i];
         if (i == 0) begin
            pre_gp_s[i] = bit_gp_s[i];
         end else begin
            pre_gp_s[i].g = bit_gp_s[i].g | (bit_gp_s[i].p & pre_gp_s[i-1].g);
            pre_gp_s[i].p = bit_gp_s[i].p & pre_gp_s[i-1].p;
         end
         carry_s[i+1] = pre_gp_s[i].g | (pre_gp_s[i].p & cin);
         sum[i]       = bit_gp_s[i].p ^ carry_s[i];
      end
   end

   assign cout    = carry_s[SEG_W];
   assign msb_cin = carry_s[SEG_W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one register stage per SEG_W-bit segment.
// Optional signed-overflow output is enabled by defining CLA_OVF_EN.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSEG = nseg(WIDTH, SEG_W);

   if (!seg_cfg_ok(WIDTH, SEG_W)) begin : g_bad_cfg
      $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of SEG_W");
   end

   logic             en_s;
   logic [WIDTH-1:0] eff_b_s;
   logic             eff_cin_s;

   // One global enable freezes the whole pipe while the output is stalled.
   assign en_s      = !out_valid || out_ready;
   assign in_ready  = en_s;
   assign eff_b_s   = sub ? ~b : b;
   assign eff_cin_s = cin ^ sub;

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      logic [WIDTH-1:0] a_in_s;
      logic [WIDTH-1:0] b_in_s;
      logic [WIDTH-1:0] sum_in_s;
      logic [WIDTH-1:0] sum_next_s;
      logic             cin_in_s;
      logic             valid_in_s;
      logic [SEG_W-1:0] seg_sum_s;
      logic             seg_cout_s;
      logic             seg_msb_s;
      logic [WIDTH-1:0] sum_r;
      logic             carry_r;
      logic             valid_r;

      if (k == 0) begin : g_first
         assign a_in_s     = a;
         assign b_in_s     = eff_b_s;
         assign sum_in_s   = {WIDTH{1'b0}};
         assign cin_in_s   = eff_cin_s;
         assign valid_in_s = in_valid;
      end else begin : g_next
         assign a_in_s     = g_stage[k-1].g_skew.a_r;
         assign b_in_s     = g_stage[k-1].g_skew.b_r;
         assign sum_in_s   = g_stage[k-1].sum_r;
         assign cin_in_s   = g_stage[k-1].carry_r;
         assign valid_in_s = g_stage[k-1].valid_r;
      end

      cla_segment #(.SEG_W(SEG_W)) u_seg (
         .a       (a_in_s[k*SEG_W +: SEG_W]),
         .b       (b_in_s[k*SEG_W +: SEG_W]),
         .cin     (cin_in_s),
         .sum     (seg_sum_s),
         .cout    (seg_cout_s),
         .msb_cin (seg_msb_s)
      );

      // Completed low segments ride along; this stage fills in its own slice.
      always_comb begin
         sum_next_s                     = sum_in_s;
         sum_next_s[k*SEG_W +: SEG_W]   = seg_sum_s;
      end

      // Stage result, carry and valid registers.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            valid_r <= 1'b0;
         end else if (en_s) begin
            sum_r   <= sum_next_s;
            carry_r <= seg_cout_s;
            valid_r <= valid_in_s;
         end
      end

      if (k < NSEG - 1) begin : g_skew
         logic [WIDTH-1:0] a_r;
         logic [WIDTH-1:0] b_r;

         // Operand skew chain feeding the next segment.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               a_r <= {WIDTH{1'b0}};
               b_r <= {WIDTH{1'b0}};
            end else if (en_s) begin
               a_r <= a_in_s;
               b_r <= b_in_s;
            end
         end
      end
   end

   assign sum       = g_stage[NSEG-1].sum_r;
   assign cout      = g_stage[NSEG-1].carry_r;
   assign out_valid = g_stage[NSEG-1].valid_r;

`ifdef CLA_OVF_EN
   logic ovf_r;

   // Overflow is the MSB carry-in vs carry-out mismatch, aligned with sum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_r <= 1'b0;
      end else if (en_s) begin
         ovf_r <= g_stage[NSEG-1].seg_msb_s ^ g_stage[NSEG-1].seg_cout_s;
      end
   end

   assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed self-checking bench for pipelined_cla_adder (WIDTH=8, SEG_W=4, two stages).
module tb_pipelined_cla_adder;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       sub;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;
`ifdef CLA_OVF_EN
   logic       ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] vec_a   [8];
   logic [7:0] vec_b   [8];
   logic       vec_cin [8];
   logic       vec_sub [8];
   logic [7:0] exp_sum [8];
   logic       exp_cout[8];
   logic       exp_ovf [8];
   int         n_vec;

   pipelined_cla_adder #(.WIDTH(8), .SEG_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef CLA_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic add_vec(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic vs, input logic [7:0] es, input logic ec, input logic eo);
      vec_a[n_vec]    = va;
      vec_b[n_vec]    = vb;
      vec_cin[n_vec]  = vc;
      vec_sub[n_vec]  = vs;
      exp_sum[n_vec]  = es;
      exp_cout[n_vec] = ec;
      exp_ovf[n_vec]  = eo;
      n_vec++;
   endtask

   // Streams the queued vectors back-to-back and expects each result two cycles after its accept.
   task automatic run_group(input string name);
      for (int i = 0; i < n_vec + 2; i++) begin
         @(negedge clk);
         check_val({name, "_in_ready"}, 32'(in_ready), 32'd1);
         if (i >= 2) begin
            check_val($sformatf("%s_valid%0d", name, i - 2), 32'(out_valid), 32'd1);
            check_val($sformatf("%s_sum%0d", name, i - 2), 32'(sum), 32'(exp_sum[i-2]));
            check_val($sformatf("%s_cout%0d", name, i - 2), 32'(cout), 32'(exp_cout[i-2]));
`ifdef CLA_OVF_EN
            check_val($sformatf("%s_ovf%0d", name, i - 2), 32'(ovf), 32'(exp_ovf[i-2]));
`endif
         end else begin
            check_val($sformatf("%s_idle%0d", name, i), 32'(out_valid), 32'd0);
         end
         if (i < n_vec) begin
            in_valid = 1'b1;
            a        = vec_a[i];
            b        = vec_b[i];
            cin      = vec_cin[i];
            sub      = vec_sub[i];
         end else begin
            in_valid = 1'b0;
         end
      end
      n_vec = 0;
   endtask

   initial begin
      n_vec     = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      a         = 8'd0;
      b         = 8'd0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_sum", 32'(sum), 32'd0);
      check_val("rst_cout", 32'(cout), 32'd0);
`ifdef CLA_OVF_EN
      check_val("rst_ovf", 32'(ovf), 32'd0);
`endif
      reset = 1'b0;
      #1;
      check_val("rst_in_ready", 32'(in_ready), 32'd1);

      add_vec(8'd10, 8'd6,   1'b0, 1'b0, 8'd16,  1'b0, 1'b0);
      add_vec(8'd43, 8'd22,  1'b0, 1'b0, 8'd65,  1'b0, 1'b0);
      add_vec(8'd97, 8'd143, 1'b0, 1'b0, 8'd240, 1'b0, 1'b0);
      add_vec(8'd42, 8'd88,  1'b0, 1'b0, 8'd130, 1'b0, 1'b1);
      run_group("stream");

      add_vec(8'd255, 8'd0, 1'b1, 1'b0, 8'd0,  1'b1, 1'b0);
      add_vec(8'd15,  8'd1, 1'b0, 1'b0, 8'd16, 1'b0, 1'b0);
      run_group("carry");

      add_vec(8'd42, 8'd88, 1'b0, 1'b1, 8'd210, 1'b0, 1'b0);
      add_vec(8'd88, 8'd42, 1'b0, 1'b1, 8'd46,  1'b1, 1'b0);
      add_vec(8'd50, 8'd20, 1'b1, 1'b1, 8'd29,  1'b1, 1'b0);
      run_group("sub");

      add_vec(8'd127, 8'd1, 1'b0, 1'b0, 8'd128, 1'b0, 1'b1);
      add_vec(8'd128, 8'd1, 1'b0, 1'b1, 8'd127, 1'b1, 1'b1);
      run_group("ovf");

      // Backpressure: X=1+2, Y=5+6 in flight, Z=20+30 offered while the output stalls.
      @(negedge clk);
      in_valid = 1'b1; a = 8'd1; b = 8'd2; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      a = 8'd5; b = 8'd6;
      @(negedge clk);
      check_val("bp_first_valid", 32'(out_valid), 32'd1);
      check_val("bp_first_sum", 32'(sum), 32'd3);
      out_ready = 1'b0;
      a = 8'd20; b = 8'd30;
      #1;
      check_val("bp_in_ready_low", 32'(in_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
         check_val($sformatf("bp_hold_sum%0d", i), 32'(sum), 32'd3);
         check_val($sformatf("bp_hold_ready%0d", i), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check_val("bp_release_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      check_val("bp_second_valid", 32'(out_valid), 32'd1);
      check_val("bp_second_sum", 32'(sum), 32'd11);
      in_valid = 1'b0;
      @(negedge clk);
      check_val("bp_third_valid", 32'(out_valid), 32'd1);
      check_val("bp_third_sum", 32'(sum), 32'd50);
      @(negedge clk);
      check_val("bp_drained", 32'(out_valid), 32'd0);

      // Reset with two beats in flight.
      in_valid = 1'b1; a = 8'd100; b = 8'd1; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      a = 8'd50; b = 8'd50;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_val("mid_rst_valid", 32'(out_valid), 32'd0);
      check_val("mid_rst_sum", 32'(sum), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val($sformatf("post_rst_idle%0d", i), 32'(out_valid), 32'd0);
      end

      add_vec(8'd3, 8'd4, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0);
      run_group("post_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
